tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Receiving end of the gate-level TDM serial link. Recovers CHANNELS words of WIDTH bits
//  from a framed serial bit stream and distributes each word to its own channel register.
//  Sits after the link wire, ahead of channel consumers; sequential counterpart to _dmux.
// PARAMETERS
//  CHANNELS  4  channel words per frame (>=1)
//  WIDTH     8  bits per channel word (>=1)
// PORTS
//  clk          in   1               single clock, all state on rising edge
//  rst_n        in   1               reset, asynchronous, active-low
//  bit_in       in   1               serial data bit, MSB of each word first
//  bit_valid    in   1               bit_in is valid this cycle (gaps allowed)
//  frame_start  in   1               qualifies bit_in as first bit of a frame (only with bit_valid)
//  ch_data      out  CHANNELS*WIDTH  channel words; ch0 = [WIDTH-1:0], chN at [N*WIDTH +: WIDTH]
//  ch_valid     out  CHANNELS        1-cycle strobe: word for channel N just written
//  frame_valid  out  1               1-cycle strobe: last channel of a frame just written
//  frame_err    out  1               1-cycle strobe: frame_start seen mid-frame (resync)
//  busy         out  1               high while in SHIFT
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE, counters 0, ch_data 0, all strobes 0, busy 0.
//  - Bit order: channel 0 first; per channel MSB first; frame = CHANNELS*WIDTH valid bits.
//  - Cycles with bit_valid=0: no state change; frame_start ignored; strobes low.
//  - IDLE: bit_valid&frame_start -> bit shifted in as bit 1 of frame, -> SHIFT (WIDTH=1, CHANNELS=1:
//    frame completes same edge, stay IDLE). bit_valid without frame_start: ignored.
//  - SHIFT: each bit_valid shifts bit_in into word shift reg, bit_cnt++. On the edge sampling
//    bit WIDTH of a word: ch_data slice[ch_cnt] <= assembled word, ch_valid[ch_cnt]=1 next cycle,
//    bit_cnt<=0, ch_cnt++. Latency: strobe/data visible 1 cycle after last bit's sampling edge.
//  - Last word of frame (ch_cnt==CHANNELS-1): also frame_valid=1 with ch_valid[CHANNELS-1];
//    ch_cnt<=0, -> IDLE. Back-to-back frames: next frame_start accepted the very next cycle.
//  - frame_start&bit_valid while in SHIFT (incl. on what would be the last bit): frame_err=1
//    next cycle; partial word discarded; words already written this frame stay in ch_data; no
//    frame_valid; frame restarts with this bit as bit 1 (bit_cnt=1, ch_cnt=0), stay SHIFT.
//  - ch_data slices hold until overwritten by a newly completed word; never cleared except reset.
//  - Counters: bit_cnt width $clog2(WIDTH+1), ch_cnt width $clog2(CHANNELS+1); no wrap
//    beyond terminal counts (terminal compare, not modulo overflow).
//  - At most one ch_valid bit high in any cycle; frame_err and frame_valid never both high.
//  - Reset asserted mid-frame: everything cleared immediately; after release, bits without
//    frame_start ignored until a new frame_start.
//  - busy = (state==SHIFT), combinational from state register.
// STRUCTURE
//  - tdm_defs.vh (shared with the TDM transmitter): state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1;
//    default CHANNELS/WIDTH; bit-order/framing constants.
//  - Sub-module shift_in_reg #(WIDTH): serial-in/parallel-out register, clk, rst_n, shift_en,
//    clr, d, q[WIDTH-1:0]; tdm_demux owns FSM, counters, channel registers, strobes.
// TESTING
//  1 Reset: hold rst_n=0 with random inputs -> all outputs 0; release, bits w/o frame_start -> no strobes.
//  2 Single frame, CHANNELS=4 WIDTH=8, words A5,3C,FF,01 contiguous -> ch_valid 0001,0010,0100,1000
//    one cycle after bits 8,16,24,32; frame_valid with last; ch_data=32'h01FF3CA5.
//  3 Same frame with bit_valid=0 gaps of 1-3 cycles -> identical ch_data and strobe order.
//  4 Back-to-back frames 11,22,33,44 then 55,66,77,88 with no idle -> two frame_valid, final 32'h88776655.
//  5 frame_start at bit 13 of frame -> frame_err next cycle, ch0 kept, ch1 unchanged, new frame
//    of 4 words from bit 13 -> frame_valid, correct data.
//  6 rst_n low at bit 20, release, full frame 0F,F0,AA,55 -> ch_data=32'h55AAF00F, one frame_valid.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM serial link receiver: state encodings and
// default link geometry (channel count and word width).
package tdm_demux_pkg;

    // Receiver FSM encodings, kept as 1-bit constants so the transmitter
    // side and legacy code can share the same values.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Default link geometry.
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 8;

    // Framing: words go out channel 0 first, each word MSB first.
    localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/tdm_demux_shift_in_reg.sv
// Serial-in / parallel-out register. New bits enter at the LSB so that, with
// the word sent MSB first, the oldest bit ends up at the top. A clear
// together with a shift loads only the incoming bit (used on frame resync).
module shift_in_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] keep;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] q_d;

    // Next value: drop old contents on clear, append d at the LSB on shift.
    always_comb begin
        keep    = clr ? '0 : q_q;
        shifted = {keep, d};
        q_d     = q_q;
        if (shift_en) begin
            q_d = shifted[WIDTH-1:0];
        end else if (clr) begin
            q_d = '0;
        end
    end

    // Register update with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tdm_demux.sv
// Receiving end of the TDM serial link. Collects CHANNELS words of WIDTH bits
// from a framed serial stream (channel 0 first, MSB first) and writes each
// completed word into its own channel register with a one-cycle strobe.
//
// Handshake: there is no back-pressure. bit_in is consumed on every rising
// edge where bit_valid=1; frame_start only has meaning together with
// bit_valid. Outputs ch_valid/frame_valid/frame_err are single-cycle strobes
// that appear one cycle after the sampling edge of the bit that caused them.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      bit_in,
    input  logic                      bit_valid,
    input  logic                      frame_start,
    output logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic [CHANNELS-1:0]       ch_valid,
    output logic                      frame_valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int CCW = $clog2(CHANNELS + 1);

    logic [0:0]                state_q, state_d;
    logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [CCW-1:0]            ch_cnt_q, ch_cnt_d;
    logic [CHANNELS*WIDTH-1:0] ch_data_q, ch_data_d;
    logic [CHANNELS-1:0]       ch_valid_q, ch_valid_d;
    logic                      frame_valid_q, frame_valid_d;
    logic                      frame_err_q, frame_err_d;

    logic                      restart;
    logic                      accept;
    logic [BCW-1:0]            bit_base;
    logic [BCW-1:0]            bit_next;
    logic [CCW-1:0]            ch_base;
    logic                      word_done;
    logic                      frame_done;
    logic [WIDTH-1:0]          sr_q;
    logic [WIDTH-1:0]          sr_keep;
    logic [WIDTH:0]            word_ext;
    logic [WIDTH-1:0]          word;

    // Bit acceptance and word/frame completion. A frame_start bit always
    // begins a frame from position zero, whether idle or mid-frame.
    always_comb begin
        restart    = bit_valid & frame_start;
        accept     = bit_valid & (restart | (state_q == ST_SHIFT));
        bit_base   = restart ? '0 : bit_cnt_q;
        ch_base    = restart ? '0 : ch_cnt_q;
        bit_next   = bit_base + BCW'(1);
        word_done  = accept & (bit_next == BCW'(WIDTH));
        frame_done = word_done & (ch_base == CCW'(CHANNELS - 1));
        sr_keep    = restart ? '0 : sr_q;
        word_ext   = {sr_keep, bit_in};
        word       = word_ext[WIDTH-1:0];
    end

    // FSM, counters, channel registers and strobe next-state.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        ch_cnt_d      = ch_cnt_q;
        ch_data_d     = ch_data_q;
        ch_valid_d    = '0;
        frame_valid_d = 1'b0;
        frame_err_d   = restart & (state_q == ST_SHIFT);
        if (accept) begin
            if (word_done) begin
                bit_cnt_d  = '0;
                ch_valid_d = CHANNELS'(1) << ch_base;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (ch_base == CCW'(c)) begin
                        ch_data_d[c*WIDTH +: WIDTH] = word;
                    end
                end
                if (frame_done) begin
                    ch_cnt_d      = '0;
                    frame_valid_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    ch_cnt_d = ch_base + CCW'(1);
                    state_d  = ST_SHIFT;
                end
            end else begin
                bit_cnt_d = bit_next;
                ch_cnt_d  = ch_base;
                state_d   = ST_SHIFT;
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            ch_cnt_q      <= '0;
            ch_data_q     <= '0;
            ch_valid_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            ch_cnt_q      <= ch_cnt_d;
            ch_data_q     <= ch_data_d;
            ch_valid_q    <= ch_valid_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    shift_in_reg #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept),
        .clr      (restart),
        .d        (bit_in),
        .q        (sr_q)
    );

    assign ch_data     = ch_data_q;
    assign ch_valid    = ch_valid_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux (CHANNELS=4, WIDTH=8): directed frames plus random
// frames, gaps and resyncs, checked cycle by cycle against a frame-position
// reference model and a scoreboard of completed words.
module tb_tdm_demux;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int FB = CH * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic frame_start = 1'b0;
  logic [FB-1:0] ch_data;
  logic [CH-1:0] ch_valid;
  logic frame_valid;
  logic frame_err;
  logic busy;

  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int fv_seen = 0;
  int fe_seen = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // pos = number of frame bits received so far, -1 when no frame is open.
  int pos = -1;
  logic [W-1:0] acc;
  logic [W-1:0] m_data[CH];
  logic [CH-1:0] m_chv;
  logic m_fv;
  logic m_fe;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = -1;
    acc = '0;
    for (int c = 0; c < CH; c++) m_data[c] = '0;
    m_chv = '0;
    m_fv = 1'b0;
    m_fe = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_bit(input logic bv, input logic b, input logic fs);
    int chn;
    m_chv = '0;
    m_fv = 1'b0;
    m_fe = 1'b0;
    if (bv) begin
      if (fs) begin
        if (pos >= 0) m_fe = 1'b1;
        pos = 0;
        acc = '0;
      end
      if (pos >= 0) begin
        acc = {acc[W-2:0], b};
        pos = pos + 1;
        if (pos % W == 0) begin
          chn = pos / W - 1;
          m_data[chn] = acc;
          m_chv[chn] = 1'b1;
          exp_q.push_back(acc);
          if (pos == FB) begin
            m_fv = 1'b1;
            pos = -1;
          end
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic [FB-1:0] m_pack;
    for (int c = 0; c < CH; c++) m_pack[c*W +: W] = m_data[c];
    check("ch_valid", 64'(ch_valid), 64'(m_chv));
    check("frame_valid", 64'(frame_valid), 64'(m_fv));
    check("frame_err", 64'(frame_err), 64'(m_fe));
    check("busy", 64'(busy), 64'(pos >= 0));
    check("ch_data", 64'(ch_data), 64'(m_pack));
    if (frame_valid) fv_seen++;
    if (frame_err) fe_seen++;
    for (int c = 0; c < CH; c++) begin
      if (ch_valid[c]) begin
        if (exp_q.size() == 0) check("sb_unexpected_word", 64'(1), 64'(0));
        else check("sb_word", 64'(ch_data[c*W +: W]), 64'(exp_q.pop_front()));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic bv, input logic b, input logic fs);
    bit_valid = bv;
    bit_in = b;
    frame_start = fs;
    @(posedge clk);
    model_bit(bv, b, fs);
    #1;
    compare_outputs();
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(1, 3)) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Sends the first nbits of a frame; frame word for channel c is frame[c*W +: W].
  task automatic send_frame(input logic [FB-1:0] frame, input bit gaps, input int nbits);
    int n = 0;
    for (int c = 0; c < CH; c++) begin
      for (int i = W - 1; i >= 0; i--) begin
        if (n < nbits) begin
          if (gaps && n > 0) idle_gap();
          step(1'b1, frame[c*W + i], (n == 0));
          n++;
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ch_data"}, 64'(ch_data), 64'(0));
    check({tag, "_ch_valid"}, 64'(ch_valid), 64'(0));
    check({tag, "_frame_valid"}, 64'(frame_valid), 64'(0));
    check({tag, "_frame_err"}, 64'(frame_err), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic hold_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    repeat (cycles) begin
      bit_valid = 1'($urandom_range(0, 1));
      bit_in = 1'($urandom_range(0, 1));
      frame_start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_all_zero("in_reset");
    end
    bit_valid = 1'b0;
    frame_start = 1'b0;
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- stimulus ----------------
  int fv0;
  int fe0;

  initial begin
    model_reset();

    // 1: reset with random inputs, then stray bits without frame_start.
    hold_reset(5);
    repeat (12) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("stray_bits_data", 64'(ch_data), 64'(0));

    // 2: single contiguous frame.
    fv0 = fv_seen;
    send_frame(32'h01FF3CA5, 1'b0, FB);
    check("t2_data", 64'(ch_data), 64'h01FF3CA5);
    check("t2_fv_count", 64'(fv_seen - fv0), 64'(1));

    // 3: same frame with idle gaps.
    step(1'b0, 1'b0, 1'b0);
    send_frame(32'h01FF3CA5, 1'b1, FB);
    check("t3_data", 64'(ch_data), 64'h01FF3CA5);

    // 4: back-to-back frames.
    fv0 = fv_seen;
    send_frame(32'h44332211, 1'b0, FB);
    send_frame(32'h88776655, 1'b0, FB);
    check("t4_data", 64'(ch_data), 64'h88776655);
    check("t4_fv_count", 64'(fv_seen - fv0), 64'(2));

    // 5: resync with frame_start on bit 13.
    fv0 = fv_seen;
    fe0 = fe_seen;
    send_frame(32'h00005AC3, 1'b0, 12);
    check("t5_partial", 64'(ch_data), 64'h887766C3);
    send_frame(32'hF0DEBC9A, 1'b0, FB);
    check("t5_data", 64'(ch_data), 64'hF0DEBC9A);
    check("t5_fe_count", 64'(fe_seen - fe0), 64'(1));
    check("t5_fv_count", 64'(fv_seen - fv0), 64'(1));

    // 6: asynchronous reset at bit 20, then a full frame.
    send_frame(32'h12345678, 1'b0, 19);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    hold_reset(2);
    repeat (5) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    fv0 = fv_seen;
    send_frame(32'h55AAF00F, 1'b0, FB);
    check("t6_data", 64'(ch_data), 64'h55AAF00F);
    check("t6_fv_count", 64'(fv_seen - fv0), 64'(1));

    // Random frames: random data, gaps, truncation and stray bits.
    for (int f = 0; f < 40; f++) begin
      send_frame(FB'($urandom),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, FB - 1) : FB);
      repeat ($urandom_range(0, 3)) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
